// File: rtl/stage_1_pkg.sv
// stage_1_pkg: shared types and constants for the exponential unit's second stage.
//   Q3.23 fixed-point format parameters, the 1.0 and saturation constants,
//   the sequencer state enum, and a table of Taylor reciprocals floor(2^23/k).
package stage_1_pkg;

  localparam int unsigned Q323_W    = 26;
  localparam int unsigned Q323_FRAC = 23;

  localparam logic [Q323_W-1:0] ONE_Q323 = 26'h0800000;
  localparam logic [Q323_W-1:0] SAT_Q323 = 26'h3FFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    MUL_A,
    MUL_K,
    MUL_E
  } state_t;

  // floor(2^23 / k) for the Taylor term index k = 1..8; zero outside that range.
  function automatic logic [Q323_W-1:0] inv_k(input logic [3:0] k);
    logic [Q323_W-1:0] v;
    case (k)
      4'd1:    v = 26'd8388608;
      4'd2:    v = 26'd4194304;
      4'd3:    v = 26'd2796202;
      4'd4:    v = 26'd2097152;
      4'd5:    v = 26'd1677721;
      4'd6:    v = 26'd1398101;
      4'd7:    v = 26'd1198372;
      4'd8:    v = 26'd1048576;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fixmul_q323.sv
// fixmul_q323: combinational unsigned Q3.23 x Q3.23 multiply.
//   a, b : Q3.23 operands
//   p    : Q3.23 product, truncated; saturates to all-ones when the integer
//          part of the full product does not fit in three bits.
module fixmul_q323
  import stage_1_pkg::*;
(
  input  logic [Q323_W-1:0] a,
  input  logic [Q323_W-1:0] b,
  output logic [Q323_W-1:0] p
);

  logic [2*Q323_W-1:0] prod;
  logic                unused_lsb;

  always_comb begin
    prod       = (2*Q323_W)'(a) * (2*Q323_W)'(b);
    unused_lsb = ^prod[Q323_FRAC-1:0];
    if (prod[2*Q323_W-1:Q323_W+Q323_FRAC] != '0) begin
      p = SAT_Q323;
    end else begin
      p = prod[Q323_W+Q323_FRAC-1:Q323_FRAC];
    end
  end

endmodule

// File: rtl/stage_1.sv
// stage_1: second pipeline stage of the exponential unit.
//   Evaluates e^A by a Horner-form Taylor series of order TERMS on a single
//   shared multiplier, then scales by e^a. e^b is carried alongside untouched.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   start         one-cycle trigger (accepted only when idle)
//   A             residual x - a, Q3.23
//   E             e^a, Q3.23
//   FLOAT32_IN    e^b, float32, passed through
//   FIX_OUT       e^A * E, Q3.23 (holds between operations)
//   FLOAT32_OUT   FLOAT32_IN captured with the same operation
//   valid         one-cycle pulse when outputs update
//   busy          operation in flight
//   overrun       one-cycle pulse when a start is dropped because busy
module stage_1
  import stage_1_pkg::*;
#(
  parameter int unsigned TERMS = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [Q323_W-1:0] A,
  input  logic [Q323_W-1:0] E,
  input  logic [31:0]       FLOAT32_IN,
  output logic [Q323_W-1:0] FIX_OUT,
  output logic [31:0]       FLOAT32_OUT,
  output logic              valid,
  output logic              busy,
  output logic              overrun
);

  localparam logic [3:0] K_INIT = 4'(TERMS);

  state_t state, state_nxt;

  logic [Q323_W-1:0] a_r, e_r, r, t;
  logic [31:0]       f_r;
  logic [3:0]        k;

  logic [Q323_W-1:0] mul_a, mul_b, mul_p;
  logic [Q323_W:0]   sum;

  fixmul_q323 u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, multiplier operand select and the saturating 1.0 + t/k add.
  always_comb begin
    state_nxt = state;
    mul_a     = '0;
    mul_b     = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = MUL_A;
      end
      MUL_A: begin
        mul_a     = a_r;
        mul_b     = r;
        state_nxt = MUL_K;
      end
      MUL_K: begin
        mul_a     = t;
        mul_b     = inv_k(k);
        state_nxt = (k == 4'd1) ? MUL_E : MUL_A;
      end
      MUL_E: begin
        mul_a     = r;
        mul_b     = e_r;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    sum = {1'b0, ONE_Q323} + {1'b0, mul_p};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_r         <= '0;
      e_r         <= '0;
      f_r         <= '0;
      r           <= '0;
      t           <= '0;
      k           <= '0;
      FIX_OUT     <= '0;
      FLOAT32_OUT <= '0;
      valid       <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= start && (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= A;
            e_r <= E;
            f_r <= FLOAT32_IN;
            r   <= ONE_Q323;
            k   <= K_INIT;
          end
        end
        MUL_A: begin
          t <= mul_p;
        end
        MUL_K: begin
          r <= sum[Q323_W] ? SAT_Q323 : sum[Q323_W-1:0];
          if (k != 4'd1) k <= k - 4'd1;
        end
        MUL_E: begin
          FIX_OUT     <= mul_p;
          FLOAT32_OUT <= f_r;
          valid       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_1.sv
// tb_stage_1: self-checking bench for stage_1 against a behavioural model of
//   the truncated Horner Taylor series for e^A scaled by E.
module tb_stage_1;

  localparam int unsigned TERMS = 6;
  localparam int          LAT   = 2 * TERMS + 1;
  localparam logic [25:0] ONE   = 26'h0800000;
  localparam logic [25:0] SAT   = 26'h3FFFFFF;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [25:0] A = '0;
  logic [25:0] E = '0;
  logic [31:0] FLOAT32_IN = '0;
  logic [25:0] FIX_OUT;
  logic [31:0] FLOAT32_OUT;
  logic        valid, busy, overrun;

  int tests = 0;
  int fails = 0;

  stage_1 #(.TERMS(TERMS)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .A           (A),
    .E           (E),
    .FLOAT32_IN  (FLOAT32_IN),
    .FIX_OUT     (FIX_OUT),
    .FLOAT32_OUT (FLOAT32_OUT),
    .valid       (valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Q3.23 product: keep bits [48:23], saturate when the value reaches 8.0.
  function automatic logic [25:0] qmul(input logic [25:0] a, input logic [25:0] b);
    longint unsigned p;
    p = 64'(a) * 64'(b);
    if ((p >> 49) != 0) return SAT;
    return 26'(p >> 23);
  endfunction

  // e^a ~= 1 + a(1 + a/2(1 + a/3(...))) evaluated innermost first, times e.
  function automatic logic [25:0] model_exp(input logic [25:0] a, input logic [25:0] e);
    logic [25:0]     rr, tt;
    longint unsigned s, inv;
    rr = ONE;
    for (int kk = int'(TERMS); kk >= 1; kk--) begin
      tt  = qmul(a, rr);
      inv = 64'd8388608 / 64'(kk);
      s   = 64'(ONE) + 64'(qmul(tt, 26'(inv)));
      rr  = (s > 64'(SAT)) ? SAT : 26'(s);
    end
    return qmul(rr, e);
  endfunction

  task automatic pulse_start(input logic [25:0] a, input logic [25:0] e, input logic [31:0] f);
    A = a; E = e; FLOAT32_IN = f; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 3 * LAT; c++) begin
      @(posedge CLK); #1;
      if (valid) begin
        lat  = c;
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; start = 1'b1; A = 26'h0123456; E = ONE; FLOAT32_IN = 32'hDEADBEEF;
    repeat (3) @(posedge CLK);
    #1;
    tests++; if (FIX_OUT !== 26'h0) begin fails++; $display("FAIL reset_fix: got %h want 0", FIX_OUT); end
    tests++; if (FLOAT32_OUT !== 32'h0) begin fails++; $display("FAIL reset_flt: got %h want 0", FLOAT32_OUT); end
    tests++; if ({valid, busy, overrun} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got v/b/o=%b want 000", {valid, busy, overrun});
    end
    RST = 1'b0; start = 1'b0;
    @(posedge CLK); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_start_dropped: busy=%b want 0", busy); end
  endtask

  task automatic run_check(input string name, input logic [25:0] a, input logic [25:0] e,
                           input logic [31:0] f);
    int lat; bit seen; logic [25:0] exp_fix;
    exp_fix = model_exp(a, e);
    pulse_start(a, e, f);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL %s_busy: got %b want 1", name, busy); end
    wait_valid(lat, seen);
    tests++; if (!seen || lat != LAT) begin
      fails++; $display("FAIL %s_latency: seen=%0d lat=%0d want %0d", name, seen, lat, LAT);
    end
    tests++; if (FIX_OUT !== exp_fix) begin
      fails++; $display("FAIL %s_fix: got %h want %h", name, FIX_OUT, exp_fix);
    end
    tests++; if (FLOAT32_OUT !== f) begin
      fails++; $display("FAIL %s_flt: got %h want %h", name, FLOAT32_OUT, f);
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_end: got %b want 0", name, busy); end
    @(posedge CLK); #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL %s_valid_pulse: got %b want 0", name, valid); end
  endtask

  task automatic test_directed;
    int diff;
    run_check("unity", 26'h0, ONE, 32'h3F800000);
    tests++; if (FIX_OUT !== ONE) begin fails++; $display("FAIL unity_const: got %h want %h", FIX_OUT, ONE); end
    run_check("pass_e", 26'h0, 26'h15BF0A8, 32'h40000000);
    tests++; if (FIX_OUT !== 26'h15BF0A8) begin
      fails++; $display("FAIL pass_e_const: got %h want 15bf0a8", FIX_OUT);
    end
    run_check("e_one", ONE, ONE, 32'h12345678);
    diff = int'(FIX_OUT) - int'(26'h15BE93D);
    tests++; if (diff > 16 || diff < -16) begin
      fails++; $display("FAIL e_one_approx: got %h want 15be93d +/-16", FIX_OUT);
    end
    run_check("sat", 26'h1000000, 26'h1FFFFFF, 32'hCAFEF00D);
    tests++; if (FIX_OUT !== SAT) begin fails++; $display("FAIL sat_const: got %h want %h", FIX_OUT, SAT); end
  endtask

  task automatic test_random;
    logic [25:0] a, e;
    for (int i = 0; i < 16; i++) begin
      a = (i % 4 == 0) ? 26'($urandom) : 26'($urandom_range(0, 32'h0C00000));
      e = (i % 3 == 0) ? 26'($urandom) : 26'($urandom_range(0, 32'h0FFFFFF));
      run_check("rand", a, e, $urandom);
    end
  endtask

  task automatic test_overrun;
    int ovc = 0, vc = 0, lat = 0;
    logic [25:0] fix_seen = '0, exp_fix;
    exp_fix = model_exp(26'h0400000, 26'h0C00000);
    pulse_start(26'h0400000, 26'h0C00000, 32'h11111111);
    for (int c = 1; c <= 3 * LAT; c++) begin
      if (c == 3) begin
        A = 26'h0700000; E = 26'h0100000; FLOAT32_IN = 32'h22222222; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge CLK); #1;
      if (overrun) ovc++;
      if (valid) begin vc++; lat = c; fix_seen = FIX_OUT; end
    end
    start = 1'b0;
    tests++; if (ovc != 1) begin fails++; $display("FAIL overrun_count: got %0d want 1", ovc); end
    tests++; if (vc != 1) begin fails++; $display("FAIL overrun_valids: got %0d want 1", vc); end
    tests++; if (lat != LAT) begin fails++; $display("FAIL overrun_latency: got %0d want %0d", lat, LAT); end
    tests++; if (fix_seen !== exp_fix) begin
      fails++; $display("FAIL overrun_fix: got %h want %h", fix_seen, exp_fix);
    end
    tests++; if (FLOAT32_OUT !== 32'h11111111) begin
      fails++; $display("FAIL overrun_flt: got %h want 11111111", FLOAT32_OUT);
    end
  endtask

  task automatic test_reset_mid;
    int vc = 0;
    pulse_start(26'h0500000, ONE, 32'h33333333);
    repeat (4) begin
      @(posedge CLK); #1;
      if (valid) vc++;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    tests++; if (FIX_OUT !== 26'h0 || FLOAT32_OUT !== 32'h0) begin
      fails++; $display("FAIL rstmid_data: got fix=%h flt=%h want 0/0", FIX_OUT, FLOAT32_OUT);
    end
    tests++; if ({valid, busy, overrun} !== 3'b000) begin
      fails++; $display("FAIL rstmid_flags: got v/b/o=%b want 000", {valid, busy, overrun});
    end
    repeat (LAT + 2) begin
      @(posedge CLK); #1;
      if (valid) vc++;
    end
    tests++; if (vc != 0) begin fails++; $display("FAIL rstmid_no_valid: got %0d want 0", vc); end
    run_check("after_rst", 26'h0300000, 26'h0A00000, 32'h44444444);
  endtask

  task automatic test_back_to_back;
    int lat; bit seen;
    logic [25:0] exp1, exp2;
    exp1 = model_exp(26'h0200000, 26'h0900000);
    exp2 = model_exp(26'h0600000, 26'h0500000);
    pulse_start(26'h0200000, 26'h0900000, 32'h55555555);
    wait_valid(lat, seen);
    tests++; if (!seen || FIX_OUT !== exp1) begin
      fails++; $display("FAIL b2b_first: seen=%0d got %h want %h", seen, FIX_OUT, exp1);
    end
    // start in the valid cycle is accepted because the block is already idle
    pulse_start(26'h0600000, 26'h0500000, 32'h66666666);
    tests++; if (overrun !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL b2b_accept: got ovr=%b busy=%b want 0/1", overrun, busy);
    end
    wait_valid(lat, seen);
    tests++; if (!seen || lat != LAT) begin
      fails++; $display("FAIL b2b_latency: seen=%0d lat=%0d want %0d", seen, lat, LAT);
    end
    tests++; if (FIX_OUT !== exp2 || FLOAT32_OUT !== 32'h66666666) begin
      fails++; $display("FAIL b2b_second: got %h/%h want %h/66666666", FIX_OUT, FLOAT32_OUT, exp2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
